uart_word_arbiter: RTL and testbench
====================================

Name: uart_word_arbiter

Overview:
- Shares one 32-bit-word-to-byte UART serializer between NUM_REQ word producers (ADC sample packer, status/register readback, WiFi command responder, ...).
- Grants are round-robin, with an optional burst of up to BURST_LEN words per grant.
- Issues one word at a time to the serializer, waits for its word-complete pulse, then re-arbitrates.
- Sits between the producers and the serializer's word input in the UART path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_LEN, 4, maximum consecutive words per grant (1..15).
- TIMEOUT_CYCLES, 65535, cycles allowed in WAIT_DONE before abort (only used with UART_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester word-available level.
- req_data  input  32*NUM_REQ  flat word bus; requester i occupies bits [32*i+31:32*i].
- req_ack  output  NUM_REQ  one-cycle pulse: word of requester i taken.
- grant_id  output  clog2(NUM_REQ)  index of the current or last grant.
- busy  output  1  high whenever state is not IDLE.
- ser_en  output  1  one-cycle pulse: ser_data valid, start serializing.
- ser_data  output  32  word to serializer; bits [7:0] are sent first.
- ser_word_done  input  1  one-cycle pulse from serializer after the 4th byte completes.
- timeout_err  output  1  one-cycle pulse on watchdog abort; constant 0 without the macro.

Behaviour:
- Outputs are registered. On reset: req_ack=0, ser_en=0, ser_data=0, busy=0, grant_id=0, timeout_err=0, state=IDLE, burst_cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-operation: abort immediately. The serializer is not notified. Its pending done pulse lands in IDLE and is ignored.
- IDLE:
  - If any req is high, the winner is the first set bit searching from last_grant+1 with wrap-around.
  - Latch grant_id=winner and go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (one cycle):
  - If req[grant_id] has dropped, cancel: go to IDLE, set last_grant=grant_id, clear burst_cnt, issue nothing.
  - Otherwise, for one cycle: ser_en=1, ser_data=word of grant_id, req_ack[grant_id]=1. Then burst_cnt++ and go to WAIT_DONE.
- WAIT_DONE, on ser_word_done:
  - If req[grant_id]=1 and burst_cnt<BURST_LEN, go to ISSUE (same grant).
  - Otherwise go to IDLE, set last_grant=grant_id, clear burst_cnt.
- Latency:
  - req rises with the block idle at edge N: ser_en/req_ack are high in cycle N+2.
  - Between the done pulse and the next ser_en there are 2 cycles (ISSUE registered).
- Requester contract:
  - Hold the word stable while req is high.
  - Present the next word (or drop req) by the cycle after req_ack.
- ser_word_done is ignored outside WAIT_DONE.
- req changes outside IDLE/ISSUE evaluation are don't-care.
- Simultaneous events:
  - done and a new req from another requester arriving together: the burst continues if eligible; the other requester waits.
  - Exactly one req_ack bit is ever high at a time.
- Burst counter is 4 bits; it never wraps, because BURST_LEN ≤ 15 is enforced.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it equals TIMEOUT_CYCLES-1 without done: pulse timeout_err, set last_grant=grant_id, clear burst_cnt, go to IDLE.
  - A done pulse arriving in that same cycle wins: no error.
- Undefined: WAIT_DONE waits indefinitely; timeout_err is tied to 0 (the port still exists).

Decomposition:
- Package uart_arb_pkg:
  - State enum IDLE/ISSUE/WAIT_DONE (2 bits).
  - Localparams WORD_W=32, BURST_CNT_W=4, TMO_CNT_W=16.
  - Function clog2.
- Sub-module rr_priority_picker: combinational.
  - Inputs: req vector, last_grant.
  - Outputs: any_req, winner index.
  - Reusable by other shared-resource blocks (SPI, FIFO readout).

Test Plan:
- Single request: req=4'b0001, word 0x44332211; done pulse 10 cycles after ser_en -> ser_en once with ser_data=0x44332211, req_ack=0001 in the same cycle, busy drops 1 cycle after done.
- Round-robin fairness: req=4'b1111 held, BURST_LEN=1 -> grant order 0,1,2,3,0.
- Burst cap: requester 2 alone with req held, BURST_LEN=4 -> 4 ser_en pulses with grant 2. Then IDLE. Then re-grant to 2, since no other requester is pending.
- Burst yields after 4: req=4'b0101, requester 0 mid-burst -> after 4 words grant goes to 2 before 0 is served again.
- Cancel: req[1] asserted 1 cycle then dropped before ISSUE -> no ser_en, no req_ack, back to IDLE, last_grant=1.
- Reset and timeout:
  - Reset asserted in WAIT_DONE -> next cycle all outputs 0, state IDLE, a late done is ignored.
  - With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, no done -> timeout_err pulses 100 cycles after WAIT_DONE entry, then the next requester is granted.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART word arbiter slice.
//               State encoding, word/counter widths and a constant clog2
//               helper used to size grant indices.
// Revision    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int WORD_W      = 32;
    localparam int BURST_CNT_W = 4;
    localparam int TMO_CNT_W   = 16;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker. Searches the request
//               vector starting one past the last grant, wrapping around,
//               and reports the first set bit.
// Ports       : i_req        - request vector
//               i_last_grant - index of the previous grant
//               o_any_req    - at least one request is set
//               o_winner     - index of the selected requester
// Revision    : 1.0  initial release
// ============================================================================
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic               o_any_req,
    output logic [IDX_W-1:0]   o_winner
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    assign o_any_req = |i_req;

    // k runs 1..NUM_REQ so the last grant itself is considered last.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_arbiter
// Description : Round-robin arbiter sharing one 32-bit word UART serializer
//               between NUM_REQ producers, with bursts of up to BURST_LEN
//               words per grant. One word is in flight at a time; the
//               serializer's word-done pulse triggers the next decision.
//               Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a
//               grant after TIMEOUT_CYCLES cycles without word-done.
// Ports       : clk, reset (sync, active high)
//               req/req_data   - producer levels and flat word bus
//               req_ack        - one-cycle "word taken" pulse per producer
//               grant_id       - current or last granted index
//               busy           - arbiter not idle
//               ser_en/ser_data- one-cycle word strobe to the serializer
//               ser_word_done  - serializer finished the word
//               timeout_err    - watchdog abort pulse (0 when not built)
// Revision    : 1.0  initial release
// ============================================================================
module uart_word_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [WORD_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic                        ser_en,
    output logic [WORD_W-1:0]           ser_data,
    input  logic                        ser_word_done,
    output logic                        timeout_err
);

    localparam int GNT_W = clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("uart_word_arbiter: parameter out of range");
    end

    arb_state_t              r_state, w_state_nxt;
    logic [GNT_W-1:0]        r_grant, w_grant_nxt;
    logic [GNT_W-1:0]        r_last_grant, w_last_nxt;
    logic [BURST_CNT_W-1:0]  r_burst_cnt, w_burst_nxt;
    logic [NUM_REQ-1:0]      r_req_ack, w_ack_nxt;
    logic                    r_ser_en, w_en_nxt;
    logic [WORD_W-1:0]       r_ser_data, w_data_nxt;
    logic                    r_busy;
    logic                    r_timeout_err, w_tmo_err_nxt;

    logic                    w_any_req;
    logic [GNT_W-1:0]        w_winner;
    logic [WORD_W-1:0]       w_gnt_word;
    logic                    w_gnt_req;
    logic                    w_tmo_hit;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GNT_W)
    ) u_picker (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_any_req    (w_any_req),
        .o_winner     (w_winner)
    );

    assign w_gnt_req = req[r_grant];

    always_comb begin
        w_gnt_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GNT_W'(i)) begin
                w_gnt_word = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Held at zero outside WAIT_DONE, so it restarts on every entry.
    logic [TMO_CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != WAIT_DONE) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
        end
    end

    assign w_tmo_hit = (r_state == WAIT_DONE) &&
                       (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last_grant;
        w_burst_nxt   = r_burst_cnt;
        w_ack_nxt     = '0;
        w_en_nxt      = 1'b0;
        w_data_nxt    = r_ser_data;
        w_tmo_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!w_gnt_req) begin
                    // Producer withdrew before the word was taken.
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant;
                    w_burst_nxt = '0;
                end else begin
                    w_en_nxt            = 1'b1;
                    w_data_nxt          = w_gnt_word;
                    w_ack_nxt[r_grant]  = 1'b1;
                    w_burst_nxt         = r_burst_cnt + BURST_CNT_W'(1);
                    w_state_nxt         = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Done takes precedence over a watchdog hit in the same cycle.
                if (ser_word_done) begin
                    if (w_gnt_req && (r_burst_cnt < BURST_CNT_W'(BURST_LEN))) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_grant;
                        w_burst_nxt = '0;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                    w_last_nxt    = r_grant;
                    w_burst_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_last_grant  <= GNT_W'(NUM_REQ - 1);
            r_burst_cnt   <= '0;
            r_req_ack     <= '0;
            r_ser_en      <= 1'b0;
            r_ser_data    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_last_grant  <= w_last_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_req_ack     <= w_ack_nxt;
            r_ser_en      <= w_en_nxt;
            r_ser_data    <= w_data_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_timeout_err <= w_tmo_err_nxt;
        end
    end

    assign req_ack     = r_req_ack;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign ser_en      = r_ser_en;
    assign ser_data    = r_ser_data;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_arbiter
// Description : Directed self-checking bench for uart_word_arbiter
//               (NUM_REQ=4, BURST_LEN=4, TIMEOUT_CYCLES=100).
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_word_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   req_ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic         ser_en;
    logic [31:0]  ser_data;
    logic         ser_word_done;
    logic         timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_word_arbiter #(
        .NUM_REQ        (4),
        .BURST_LEN      (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .grant_id      (grant_id),
        .busy          (busy),
        .ser_en        (ser_en),
        .ser_data      (ser_data),
        .ser_word_done (ser_word_done),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input int i);
        return 32'hA500_0000 | (32'(i) << 16) | (32'(i) << 4) | 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ser_en(input int max_cycles, output int waited);
        waited = 0;
        while (ser_en !== 1'b1 && waited < max_cycles) begin
            step();
            waited++;
        end
    endtask

    task automatic pulse_done();
        ser_word_done = 1'b1;
        step();
        ser_word_done = 1'b0;
    endtask

    // Expect one word from exp_g, then present req_after and complete it.
    task automatic serve(input string tag, input int exp_g, input logic [3:0] req_after);
        int         waited;
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << exp_g;
        wait_ser_en(6, waited);
        chk({tag, "_en"},   32'(ser_en),   32'd1);
        chk({tag, "_gnt"},  32'(grant_id), 32'(exp_g));
        chk({tag, "_ack"},  32'(req_ack),  32'(exp_ack));
        chk({tag, "_data"}, ser_data,      word(exp_g));
        req = req_after;
        step();
        chk({tag, "_pulse"}, 32'({ser_en, req_ack}), 32'd0);
        step();
        pulse_done();
    endtask

    initial begin
        int n;
        int waited;

        reset         = 1'b1;
        req           = '0;
        req_data      = '0;
        ser_word_done = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_ack",  32'(req_ack),     32'd0);
        chk("rst_en",   32'(ser_en),      32'd0);
        chk("rst_data", ser_data,         32'd0);
        chk("rst_busy", 32'(busy),        32'd0);
        chk("rst_gnt",  32'(grant_id),    32'd0);
        chk("rst_tmo",  32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Single request: latency, single pulse, busy drop after done
        req_data[31:0] = 32'h4433_2211;
        req            = 4'b0001;
        step();
        chk("t1_issue_en",   32'(ser_en), 32'd0);
        chk("t1_issue_busy", 32'(busy),   32'd1);
        step();
        chk("t1_en",   32'(ser_en),   32'd1);
        chk("t1_data", ser_data,      32'h4433_2211);
        chk("t1_ack",  32'(req_ack),  32'b0001);
        chk("t1_gnt",  32'(grant_id), 32'd0);
        req = 4'b0000;
        step();
        chk("t1_pulse", 32'({ser_en, req_ack}), 32'd0);
        n = 0;
        repeat (8) begin
            step();
            n += int'(ser_en);
        end
        chk("t1_quiet", 32'(n), 32'd0);
        ser_word_done = 1'b1;
        chk("t1_busy_hold", 32'(busy), 32'd1);
        step();
        ser_word_done = 1'b0;
        chk("t1_busy_drop", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = word(i);

        // Fresh reset so requester 0 has first priority again
        reset = 1'b1;
        step();
        reset = 1'b0;

        // All four held: bursts of 4 in order 0,1,2,3
        req = 4'b1111;
        for (int k = 0; k < 16; k++) serve("rr", k / 4, (k == 15) ? 4'b0101 : 4'b1111);

        // 0 and 2 pending: 0 bursts 4, yields to 2, then back to 0
        for (int k = 0; k < 8; k++) serve("yield", (k < 4) ? 0 : 2, 4'b0101);
        serve("yield_back", 0, 4'b0100);

        // Requester 2 alone: capped at 4, idles, then re-granted
        for (int k = 0; k < 4; k++) serve("cap", 2, 4'b0100);
        chk("cap_idle", 32'(busy), 32'd0);
        serve("regrant", 2, 4'b0000);

        // Cancel: req[1] drops before ISSUE
        req = 4'b0010;
        step();
        chk("cancel_gnt",  32'(grant_id), 32'd1);
        chk("cancel_busy", 32'(busy),     32'd1);
        req = 4'b0000;
        step();
        chk("cancel_none", 32'({ser_en, req_ack}), 32'd0);
        chk("cancel_idle", 32'(busy),              32'd0);
        // last_grant=1 makes 2 win over 1
        req = 4'b0110;
        serve("cancel_next", 2, 4'b0000);

        // Reset while waiting for done; late done ignored
        req = 4'b0001;
        wait_ser_en(6, waited);
        chk("rw_en", 32'(ser_en), 32'd1);
        step();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        chk("rw_busy", 32'(busy),        32'd0);
        chk("rw_en0",  32'(ser_en),      32'd0);
        chk("rw_ack",  32'(req_ack),     32'd0);
        chk("rw_data", ser_data,         32'd0);
        chk("rw_gnt",  32'(grant_id),    32'd0);
        chk("rw_tmo",  32'(timeout_err), 32'd0);
        reset = 1'b0;
        pulse_done();
        chk("late_done_busy", 32'(busy), 32'd0);
        step();
        chk("late_done_en", 32'(ser_en), 32'd0);

        // Watchdog
        req = 4'b1000;
        wait_ser_en(6, waited);
        chk("tmo_en",  32'(ser_en),   32'd1);
        chk("tmo_gnt", 32'(grant_id), 32'd3);
`ifdef UART_ARB_TIMEOUT_EN
        req = 4'b1001;
        n   = 0;
        while (timeout_err !== 1'b1 && n < 150) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n),           32'd100);
        chk("tmo_err",    32'(timeout_err), 32'd1);
        chk("tmo_busy",   32'(busy),        32'd0);
        step();
        chk("tmo_pulse",  32'(timeout_err), 32'd0);
        serve("tmo_next", 0, 4'b0000);
`else
        n = 0;
        repeat (150) begin
            step();
            n += int'(timeout_err);
        end
        chk("notmo_err",  32'(n),    32'd0);
        chk("notmo_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        pulse_done();
        chk("notmo_idle", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
